// File: rtl/pid_uart_pkg.sv
// pid_uart_pkg
// Shared definitions for the UART telemetry framer: default frame header,
// frame length, FSM state encoding and the frame checksum helper.
package pid_uart_pkg;

   localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
   localparam int         FRAME_LEN      = 5;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_RDY = 2'd1,
      WAIT_ACK = 2'd2
   } tx_state_e;

   // Header byte is deliberately left out of the checksum.
   function automatic logic [7:0] calc_chk(input logic [7:0] seq, input logic [15:0] smp);
      return seq ^ smp[15:8] ^ smp[7:0];
   endfunction

endpackage

// File: rtl/sat_counter8.sv
// sat_counter8
// 8-bit up-counter that sticks at 255 instead of wrapping.
// Ports:
//   clk_in  - clock
//   reset   - synchronous, active-low clear
//   inc     - count one event this cycle
//   count   - current count
module sat_counter8 (
   input  logic       clk_in,
   input  logic       reset,
   input  logic       inc,
   output logic [7:0] count
);

   always_ff @(posedge clk_in) begin
      if (!reset) begin
         count <= 8'd0;
      end else if (inc && (count != 8'hFF)) begin
         count <= count + 8'd1;
      end
   end

endmodule

// File: rtl/pid_telemetry_tx.sv
// pid_telemetry_tx
// Frames 16-bit PID telemetry samples into 5-byte packets
// (HEADER, seq, sample MSB, sample LSB, chk) and hands them byte by byte to
// the UART byte transmitter through its send/send_data/send_rdy handshake.
// Ports:
//   clk_in       - transmitter clock
//   reset        - synchronous, active-low
//   sample_valid - sample offered this cycle
//   sample       - telemetry word
//   send_rdy     - transmitter idle, can take a byte
//   send         - one-cycle byte strobe
//   send_data    - byte to transmit, held between strobes
//   busy         - frame in progress, samples refused
//   frame_done   - one-cycle pulse when the last byte is handed off
//   drop_cnt     - saturating count of refused samples
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | no frame; accepts a sample once busy has dropped
// WAIT_RDY | byte idx pending; strobes it out when send_rdy is high
// WAIT_ACK | byte strobed; waits for send_rdy low or the ack timeout
module pid_telemetry_tx
   import pid_uart_pkg::*;
#(
   parameter logic [7:0] HEADER      = HEADER_DEFAULT,
   parameter int         ACK_TIMEOUT = 4
) (
   input  logic        clk_in,
   input  logic        reset,
   input  logic        sample_valid,
   input  logic [15:0] sample,
   input  logic        send_rdy,
   output logic        send,
   output logic [7:0]  send_data,
   output logic        busy,
   output logic        frame_done,
   output logic [7:0]  drop_cnt
);

   // Timer counts down from ACK_TIMEOUT-1; the strobe cycle itself is the
   // first WAIT_ACK cycle, so the state lasts ACK_TIMEOUT cycles at most.
   localparam int            TW       = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [TW-1:0] TMO_LOAD = TW'(ACK_TIMEOUT - 1);
   localparam logic [TW-1:0] TMO_ONE  = TW'(1);
   localparam logic [2:0]    LAST_IDX = 3'(FRAME_LEN - 1);

   tx_state_e     state;
   logic [2:0]    idx;
   logic [7:0]    seq;
   logic [15:0]   smp_q;
   logic [7:0]    seq_q;
   logic [7:0]    chk_q;
   logic [TW-1:0] tmo;
   logic [7:0]    cur_byte;
   logic          accept;
   logic          drop;

   // busy stays high through the frame_done cycle, so a sample offered
   // there is dropped rather than accepted.
   assign accept = sample_valid && !busy;
   assign drop   = sample_valid && busy;

   always_comb begin
      cur_byte = HEADER;
      case (idx)
         3'd0:    cur_byte = HEADER;
         3'd1:    cur_byte = seq_q;
         3'd2:    cur_byte = smp_q[15:8];
         3'd3:    cur_byte = smp_q[7:0];
         3'd4:    cur_byte = chk_q;
         default: cur_byte = HEADER;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (!reset) begin
         state      <= IDLE;
         idx        <= 3'd0;
         seq        <= 8'd0;
         smp_q      <= 16'd0;
         seq_q      <= 8'd0;
         chk_q      <= 8'd0;
         tmo        <= '0;
         send       <= 1'b0;
         send_data  <= 8'd0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         send       <= 1'b0;
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  smp_q <= sample;
                  seq_q <= seq;
                  chk_q <= calc_chk(seq, sample);
                  seq   <= seq + 8'd1;
                  idx   <= 3'd0;
                  busy  <= 1'b1;
                  state <= WAIT_RDY;
               end else begin
                  busy <= 1'b0;
               end
            end
            WAIT_RDY: begin
               if (send_rdy) begin
                  send      <= 1'b1;
                  send_data <= cur_byte;
                  tmo       <= TMO_LOAD;
                  state     <= WAIT_ACK;
               end
            end
            WAIT_ACK: begin
               if (!send_rdy || (tmo == '0)) begin
                  if (idx == LAST_IDX) begin
                     frame_done <= 1'b1;
                     state      <= IDLE;
                  end else begin
                     idx   <= idx + 3'd1;
                     state <= WAIT_RDY;
                  end
               end else begin
                  tmo <= tmo - TMO_ONE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   sat_counter8 u_drop_cnt (
      .clk_in (clk_in),
      .reset  (reset),
      .inc    (drop),
      .count  (drop_cnt)
   );

endmodule

// File: tb/tb_pid_telemetry_tx.sv
module tb_pid_telemetry_tx;

   typedef struct {
      logic [15:0] smp;
      logic [7:0]  seq;
      logic [7:0]  chk;
   } vec_t;

   logic        clk_in = 1'b0;
   logic        reset = 1'b0;
   logic        sample_valid = 1'b0;
   logic [15:0] sample = 16'd0;
   logic        send_rdy = 1'b1;
   logic        send;
   logic [7:0]  send_data;
   logic        busy;
   logic        frame_done;
   logic [7:0]  drop_cnt;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int rdy_mode = 0;       // 0: transmitter model, 1: stuck high, 2: stuck low
   bit pend = 0;
   int low_left = 0;
   bit prev_send = 0;
   int done_cnt = 0;
   logic [7:0] got[$];
   int t_send[$];

   pid_telemetry_tx #(.HEADER(8'hA5), .ACK_TIMEOUT(4)) dut (
      .clk_in       (clk_in),
      .reset        (reset),
      .sample_valid (sample_valid),
      .sample       (sample),
      .send_rdy     (send_rdy),
      .send         (send),
      .send_data    (send_data),
      .busy         (busy),
      .frame_done   (frame_done),
      .drop_cnt     (drop_cnt)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock; outputs are observed 1 time unit after the edge and the
   // transmitter model updates send_rdy for the coming cycle.
   task automatic tick();
      @(posedge clk_in);
      #1;
      cyc++;
      case (rdy_mode)
         1: send_rdy = 1'b1;
         2: send_rdy = 1'b0;
         default: begin
            if (pend) begin
               send_rdy = 1'b0;
               low_left = 2;
               pend = 0;
            end else if (low_left > 0) begin
               low_left--;
               if (low_left == 0) send_rdy = 1'b1;
            end
         end
      endcase
      if (send === 1'b1) begin
         check("no_back_to_back_send", prev_send, 0);
         got.push_back(send_data);
         t_send.push_back(cyc);
         pend = 1;
      end
      if (frame_done === 1'b1) done_cnt++;
      prev_send = (send === 1'b1);
   endtask

   task automatic set_mode(input int m);
      rdy_mode = m;
      pend = 0;
      low_left = 0;
      send_rdy = (m != 2);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100 && busy !== 1'b0; i++) tick();
      if (busy !== 1'b0) check("idle_timeout", busy, 0);
   endtask

   task automatic begin_frame(input logic [15:0] s);
      got.delete();
      t_send.delete();
      done_cnt = 0;
      sample = s;
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 400 && done_cnt == 0; i++) tick();
      if (done_cnt == 0) check("frame_done_timeout", 0, 1);
   endtask

   task automatic run_frame(input logic [15:0] s, input bit full);
      wait_idle();
      begin_frame(s);
      if (full) check("busy_after_accept", busy, 1);
      wait_done();
      tick();
      if (full) begin
         check("busy_after_frame", busy, 0);
         check("single_frame_done", done_cnt, 1);
      end
   endtask

   task automatic check_frame(input string tag, input logic [7:0] sq,
                              input logic [15:0] s, input logic [7:0] ck);
      logic [7:0] e[5];
      e[0] = 8'hA5;
      e[1] = sq;
      e[2] = s[15:8];
      e[3] = s[7:0];
      e[4] = ck;
      check({tag, "_len"}, got.size(), 5);
      for (int i = 0; i < 5; i++) begin
         if (i < got.size()) check($sformatf("%s_byte%0d", tag, i), got[i], e[i]);
      end
   endtask

   vec_t vecs[5];

   initial begin
      vecs[0] = '{16'h1234, 8'h00, 8'h26};
      vecs[1] = '{16'hFFFF, 8'h01, 8'h01};
      vecs[2] = '{16'h0000, 8'h02, 8'h02};
      vecs[3] = '{16'hA55A, 8'h03, 8'hFC};
      vecs[4] = '{16'h8001, 8'h04, 8'h85};

      // reset state
      reset = 1'b0;
      repeat (3) tick();
      reset = 1'b1;
      tick();
      check("rst_send", send, 0);
      check("rst_send_data", send_data, 0);
      check("rst_busy", busy, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_drop_cnt", drop_cnt, 0);

      // table-driven frames
      for (int v = 0; v < 5; v++) begin
         run_frame(vecs[v].smp, 1);
         check_frame($sformatf("vec%0d", v), vecs[v].seq, vecs[v].smp, vecs[v].chk);
         check("vec_drop_cnt", drop_cnt, 0);
      end

      // three drops mid-frame leave the frame intact
      wait_idle();
      begin_frame(16'h0BEE);
      for (int k = 0; k < 3; k++) begin
         tick();
         tick();
         sample = 16'hDEAD + 16'(k);
         sample_valid = 1'b1;
         tick();
         sample_valid = 1'b0;
      end
      wait_done();
      tick();
      check_frame("drops", 8'h05, 16'h0BEE, 8'hE0);
      check("drop_cnt_3", drop_cnt, 3);

      // sample in the frame_done cycle is dropped, next cycle accepted
      wait_idle();
      begin_frame(16'h1111);
      for (int i = 0; i < 400 && frame_done !== 1'b1; i++) tick();
      check("fd_seen", frame_done, 1);
      check_frame("fd_frame", 8'h06, 16'h1111, 8'h06);
      sample = 16'h2222;
      sample_valid = 1'b1;
      tick();
      check("fd_offer_dropped", drop_cnt, 4);
      check("fd_busy_falls", busy, 0);
      got.delete();
      t_send.delete();
      done_cnt = 0;
      sample = 16'h3333;
      tick();
      sample_valid = 1'b0;
      check("next_offer_accepted", busy, 1);
      check("next_offer_no_drop", drop_cnt, 4);
      wait_done();
      tick();
      check_frame("after_fd", 8'h07, 16'h3333, 8'h07);

      // send_rdy stuck high: timeout advances every byte
      set_mode(1);
      wait_idle();
      begin_frame(16'hC0DE);
      wait_done();
      tick();
      check_frame("stuck1", 8'h08, 16'hC0DE, 8'h16);
      for (int i = 1; i < t_send.size(); i++)
         check($sformatf("stuck1_gap%0d", i), t_send[i] - t_send[i-1], 5);

      // reset after byte 2 abandons the frame
      set_mode(0);
      wait_idle();
      begin_frame(16'h4242);
      for (int i = 0; i < 200 && got.size() < 3; i++) tick();
      check("mid_bytes_sent", got.size(), 3);
      reset = 1'b0;
      tick();
      check("mid_rst_send", send, 0);
      check("mid_rst_send_data", send_data, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_frame_done", frame_done, 0);
      check("mid_rst_drop_cnt", drop_cnt, 0);
      reset = 1'b1;
      set_mode(0);
      repeat (10) tick();
      check("not_resumed", got.size(), 3);
      run_frame(16'h5678, 1);
      check_frame("post_rst", 8'h00, 16'h5678, 8'h2E);

      // seq wrap 255 -> 0
      for (int f = 1; f < 255; f++) run_frame(16'(f), 0);
      run_frame(16'h00FF, 1);
      check_frame("seq255", 8'hFF, 16'h00FF, 8'h00);
      run_frame(16'h0102, 1);
      check_frame("seq_wrap", 8'h00, 16'h0102, 8'h03);

      // send_rdy stuck low: stalls with no send; drop counter saturates
      set_mode(2);
      tick();
      wait_idle();
      begin_frame(16'h9999);
      repeat (20) tick();
      check("stuck0_busy", busy, 1);
      check("stuck0_no_send", got.size(), 0);
      sample_valid = 1'b1;
      for (int k = 0; k < 300; k++) begin
         tick();
         if (k == 253) check("drop_cnt_254", drop_cnt, 254);
      end
      sample_valid = 1'b0;
      tick();
      check("drop_cnt_sat", drop_cnt, 255);
      check("stuck0_still_no_send", got.size(), 0);
      reset = 1'b0;
      tick();
      reset = 1'b1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
